// File: rtl/motor_ramp_ctrl.sv
// Command stage ahead of the motor PWM: slews duty toward the target, reverses via ramp-down and dead time.
// Optional emergency-stop input is compiled in when MOTOR_ESTOP_EN is defined.
module motor_ramp_ctrl #(
  parameter int STEP_DIV = 1000,
  parameter int STEP     = 1,
  parameter int DEADTIME = 50000
) (
  input  logic       cin,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_speed,
`ifdef MOTOR_ESTOP_EN
  input  logic       estop,
`endif
  output logic       motor_enable,
  output logic       motor_dir,
  output logic [7:0] duty_cycle,
  output logic       at_target,
  output logic       busy
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEADTIME - 1);
  localparam logic [8:0]    STEP9      = 9'(STEP);
  localparam logic [7:0]    STEP8      = 8'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, REVERSE, DEAD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    duty_q, duty_d;
  logic          dir_q, dir_d;
  logic [7:0]    tgt_speed_q, tgt_speed_d;
  logic          tgt_dir_q, tgt_dir_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dead_q, dead_d;
  logic          enable_q, enable_d;
  logic          ready_q, ready_d;
  logic          at_q, at_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic          accept;

  assign tick   = (presc_q == PRESC_LAST);
  assign accept = cmd_valid & ready_q;

  // The distance is taken in 9 bits, so a step is only applied when it cannot overshoot or wrap.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] cur9;
    logic [8:0] tgt9;
    logic [8:0] dist9;
    logic [7:0] res;
    cur9  = {1'b0, cur};
    tgt9  = {1'b0, tgt};
    dist9 = (tgt9 >= cur9) ? (tgt9 - cur9) : (cur9 - tgt9);
    if (dist9 <= STEP9) begin
      res = tgt;
    end else if (tgt9 > cur9) begin
      res = cur + STEP8;
    end else begin
      res = cur - STEP8;
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    dir_d       = dir_q;
    dead_d      = dead_q;
    tgt_speed_d = tgt_speed_q;
    tgt_dir_d   = tgt_dir_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;

    case (state_q)
      IDLE: begin
        duty_d = 8'd0;
        if (tgt_speed_q != 8'd0) begin
          dir_d   = tgt_dir_q;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tgt_dir_q != dir_q) begin
          state_d = REVERSE;
          if (tick) duty_d = slew(duty_q, 8'd0);
        end else if (duty_q == 8'd0 && tgt_speed_q == 8'd0) begin
          state_d = IDLE;
        end else if (tick) begin
          duty_d = slew(duty_q, tgt_speed_q);
        end
      end
      REVERSE: begin
        // A retarget back to the current direction aborts the reversal without dead time.
        if (tgt_dir_q == dir_q) begin
          state_d = RUN;
          if (tick) duty_d = slew(duty_q, tgt_speed_q);
        end else if (duty_q == 8'd0) begin
          state_d = DEAD;
          dead_d  = DEAD_LOAD;
        end else if (tick) begin
          duty_d = slew(duty_q, 8'd0);
        end
      end
      DEAD: begin
        if (dead_q == '0) begin
          dir_d   = tgt_dir_q;
          state_d = (tgt_speed_q != 8'd0) ? RUN : IDLE;
        end else begin
          dead_d = dead_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      tgt_speed_d = cmd_speed;
      tgt_dir_d   = cmd_dir;
    end

`ifdef MOTOR_ESTOP_EN
    if (estop) begin
      duty_d      = 8'd0;
      tgt_speed_d = 8'd0;
      state_d     = DEAD;
      dead_d      = DEAD_LOAD;
    end
`endif

    // Outputs are registered from next-state values so they line up with the state they describe.
    enable_d = ((state_d == RUN) || (state_d == REVERSE)) && (duty_d != 8'd0);
    ready_d  = (state_d != DEAD);
    at_d     = (duty_d == tgt_speed_d) && (dir_d == tgt_dir_d) &&
               ((state_d == IDLE) || (state_d == RUN));
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      duty_q      <= 8'd0;
      dir_q       <= 1'b1;
      tgt_speed_q <= 8'd0;
      tgt_dir_q   <= 1'b1;
      presc_q     <= '0;
      dead_q      <= '0;
      enable_q    <= 1'b0;
      ready_q     <= 1'b1;
      at_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      tgt_speed_q <= tgt_speed_d;
      tgt_dir_q   <= tgt_dir_d;
      presc_q     <= presc_d;
      dead_q      <= dead_d;
      enable_q    <= enable_d;
      ready_q     <= ready_d;
      at_q        <= at_d;
      busy_q      <= busy_d;
    end
  end

  assign duty_cycle   = duty_q;
  assign motor_dir    = dir_q;
  assign motor_enable = enable_q;
  assign cmd_ready    = ready_q;
  assign at_target    = at_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: cycle-by-cycle reference model, directed ramp/reversal/reset sequences,
// a table of settle-to-target commands and a randomized command phase.
module tb_motor_ramp_ctrl;
  localparam int DIV = 4;
  localparam int STP = 16;
  localparam int DT  = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_REV = 2, M_DEAD = 3;

  logic       cin = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b1;
  logic [7:0] cmd_speed = 8'd0;
  logic       cmd_ready, motor_enable, motor_dir, at_target, busy;
  logic [7:0] duty_cycle;
`ifdef MOTOR_ESTOP_EN
  logic       estop = 1'b0;
`endif

  motor_ramp_ctrl #(.STEP_DIV(DIV), .STEP(STP), .DEADTIME(DT)) dut (
    .cin(cin), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_speed(cmd_speed),
`ifdef MOTOR_ESTOP_EN
    .estop(estop),
`endif
    .motor_enable(motor_enable), .motor_dir(motor_dir), .duty_cycle(duty_cycle),
    .at_target(at_target), .busy(busy)
  );

  always #5 cin = ~cin;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: plain integers, remaining dead cycles counted from DT down to 1.
  int m_duty, m_tgt_s, m_p, m_left, m_mode;
  bit m_dir, m_tgt_d, m_en, m_rdy, m_at, m_busy;

  int q_vals[$];
  int q_when[$];
  int q_en[$];
  int n_dead, n_bad;

  typedef struct {
    bit dir;
    int speed;
    int exp_duty;
    bit exp_dir;
    bit exp_en;
  } row_t;
  row_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int approach(input int c, input int t);
    if (t - c <= STP && c - t <= STP) return t;
    return (t > c) ? c + STP : c - STP;
  endfunction

  task automatic model_outputs();
    m_en   = (m_mode == M_RUN || m_mode == M_REV) && m_duty != 0;
    m_rdy  = (m_mode != M_DEAD);
    m_at   = (m_duty == m_tgt_s) && (m_dir == m_tgt_d) && (m_mode == M_IDLE || m_mode == M_RUN);
    m_busy = (m_mode != M_IDLE);
  endtask

  task automatic model_reset();
    m_duty = 0; m_tgt_s = 0; m_p = 0; m_left = 0; m_mode = M_IDLE;
    m_dir = 1'b1; m_tgt_d = 1'b1;
    model_outputs();
  endtask

  task automatic model_step();
    bit tick, acc, td;
    int ts;
    tick = (m_p == DIV - 1);
    m_p  = tick ? 0 : m_p + 1;
    acc  = cmd_valid && m_rdy;
    ts   = m_tgt_s;
    td   = m_tgt_d;
    case (m_mode)
      M_IDLE: if (ts != 0) begin m_dir = td; m_mode = M_RUN; end
      M_RUN: begin
        if (td != m_dir) begin
          m_mode = M_REV;
          if (tick) m_duty = approach(m_duty, 0);
        end else if (m_duty == 0 && ts == 0) m_mode = M_IDLE;
        else if (tick) m_duty = approach(m_duty, ts);
      end
      M_REV: begin
        if (td == m_dir) begin
          m_mode = M_RUN;
          if (tick) m_duty = approach(m_duty, ts);
        end else if (m_duty == 0) begin
          m_mode = M_DEAD; m_left = DT;
        end else if (tick) m_duty = approach(m_duty, 0);
      end
      default: begin
        if (m_left == 1) begin
          m_dir = td; m_mode = (ts != 0) ? M_RUN : M_IDLE;
        end else m_left--;
      end
    endcase
    if (acc) begin m_tgt_s = int'(cmd_speed); m_tgt_d = cmd_dir; end
`ifdef MOTOR_ESTOP_EN
    if (estop) begin m_duty = 0; m_tgt_s = 0; m_mode = M_DEAD; m_left = DT; end
`endif
    model_outputs();
  endtask

  // One clock: advance the model at the edge, compare every output at the falling edge.
  task automatic cycle();
    @(posedge cin);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge cin);
    n_checks++;
    if (motor_enable == m_en && motor_dir == m_dir && cmd_ready == m_rdy &&
        at_target == m_at && busy == m_busy && int'(duty_cycle) == m_duty)
      n_pass++;
    else
      $display("FAIL cycle t=%0t en/dir/rdy/at/busy/duty got %b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
               $time, motor_enable, motor_dir, cmd_ready, at_target, busy, duty_cycle,
               m_en, m_dir, m_rdy, m_at, m_busy, m_duty);
  endtask

  task automatic send(input bit d, input int s);
    cmd_valid = 1'b1; cmd_dir = d; cmd_speed = 8'(s);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic settle(input int budget, input int want_busy, input string tag);
    int k;
    int last;
    q_vals.delete(); q_when.delete(); q_en.delete();
    n_dead = 0; n_bad = 0; k = 0; last = int'(duty_cycle);
    while (k < budget && !(at_target && (want_busy < 0 || int'(busy) == want_busy))) begin
      cycle();
      k++;
      if (int'(duty_cycle) != last) begin
        q_vals.push_back(int'(duty_cycle));
        q_when.push_back(k);
        q_en.push_back(int'(motor_enable));
        last = int'(duty_cycle);
      end
      if (!cmd_ready) n_dead++;
      if (motor_enable && !cmd_ready) n_bad++;
    end
    check({tag, "_settled"}, int'(k < budget), 1);
  endtask

  task automatic wait_duty(input int v, input int budget, input string tag);
    int k;
    k = 0;
    while (int'(duty_cycle) != v && k < budget) begin cycle(); k++; end
    check({tag, "_reach"}, int'(duty_cycle), v);
  endtask

  task automatic check_seq(input string tag, input int exp[8], input int n);
    check({tag, "_len"}, q_vals.size(), n);
    for (int i = 0; i < n && i < q_vals.size(); i++)
      check($sformatf("%s_val%0d", tag, i), q_vals[i], exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea[8];
    int drops;
    int n;
    tbl[0] = '{1'b1, 100, 100, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 100, 100, 1'b1, 1'b1};
    tbl[2] = '{1'b0,   0,   0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 255, 255, 1'b0, 1'b1};
    tbl[4] = '{1'b0,   0,   0, 1'b0, 1'b0};
    tbl[5] = '{1'b1,   1,   1, 1'b1, 1'b1};
    tbl[6] = '{1'b1,   0,   0, 1'b1, 1'b0};

    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    check("reset_duty", int'(duty_cycle), 0);
    check("reset_dir", int'(motor_dir), 1);
    check("reset_en", int'(motor_enable), 0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_at_target", int'(at_target), 1);
    check("reset_busy", int'(busy), 0);

    // Ramp up 0 -> 64 in steps of 16, one step per prescaler period.
    send(1'b1, 64);
    settle(100, 1, "rampA");
    ea = '{16, 32, 48, 64, 0, 0, 0, 0};
    check_seq("rampA", ea, 4);
    for (int i = 1; i < q_when.size(); i++)
      check($sformatf("rampA_spacing%0d", i), q_when[i] - q_when[i-1], DIV);
    if (q_en.size() > 0) check("rampA_en_first_nonzero", q_en[0], 1);
    check("rampA_at_target", int'(at_target), 1);

    // Reversal: down to 0, exactly DT dead cycles, flip, up to 40.
    send(1'b0, 40);
    settle(400, 1, "revB");
    ea = '{48, 32, 16, 0, 16, 32, 40, 0};
    check_seq("revB", ea, 7);
    check("revB_dead_cycles", n_dead, DT);
    check("revB_en_in_dead", n_bad, 0);
    check("revB_dir", int'(motor_dir), 0);

    // Saturation near full scale, then landing exactly on a small target.
    send(1'b0, 250);
    settle(400, 1, "satC");
    drops = 0;
    for (int i = 1; i < q_vals.size(); i++) if (q_vals[i] < q_vals[i-1]) drops++;
    check("satC_monotonic", drops, 0);
    n = q_vals.size();
    if (n >= 2) begin
      check("satC_prev", q_vals[n-2], 248);
      check("satC_last", q_vals[n-1], 250);
    end
    send(1'b0, 5);
    settle(400, 1, "downC");
    n = q_vals.size();
    if (n >= 2) begin
      check("downC_first", q_vals[0], 234);
      check("downC_prev", q_vals[n-2], 10);
      check("downC_last", q_vals[n-1], 5);
    end

    // Reversal aborted at duty 32 by a command back to the original direction.
    send(1'b0, 64);
    settle(200, 1, "preD");
    send(1'b1, 64);
    wait_duty(32, 40, "abortD");
    check("abortD_dir_mid", int'(motor_dir), 0);
    send(1'b0, 48);
    settle(200, 1, "abortD");
    check("abortD_dead_cycles", n_dead, 0);
    check("abortD_dir", int'(motor_dir), 0);
    check("abortD_duty", int'(duty_cycle), 48);

    // Asynchronous reset while ramping down through 32.
    send(1'b0, 0);
    wait_duty(32, 40, "rstE");
    check("rstE_en_before", int'(motor_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstE_async_duty", int'(duty_cycle), 0);
    check("rstE_async_en", int'(motor_enable), 0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("rstE_busy", int'(busy), 0);
    check("rstE_ready", int'(cmd_ready), 1);

    foreach (tbl[r]) begin
      send(tbl[r].dir, tbl[r].speed);
      settle(600, int'(tbl[r].exp_en), $sformatf("tbl%0d", r));
      check($sformatf("tbl%0d_duty", r), int'(duty_cycle), tbl[r].exp_duty);
      check($sformatf("tbl%0d_dir", r), int'(motor_dir), int'(tbl[r].exp_dir));
      check($sformatf("tbl%0d_en", r), int'(motor_enable), int'(tbl[r].exp_en));
    end

`ifdef MOTOR_ESTOP_EN
    send(1'b1, 128);
    settle(300, 1, "estopF");
    estop = 1'b1;
    cycle();
    check("estopF_duty", int'(duty_cycle), 0);
    check("estopF_en", int'(motor_enable), 0);
    cycle();
    cycle();
    estop = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && busy; k++) begin
      if (!cmd_ready) n++;
      cycle();
    end
    check("estopF_dead_after_release", n, DT);
    check("estopF_idle", int'(busy), 0);
    check("estopF_at_target", int'(at_target), 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cmd_valid = 1'b1;
        cmd_dir   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
          0:       cmd_speed = 8'd0;
          1:       cmd_speed = 8'd255;
          2:       cmd_speed = 8'($urandom_range(0, 24));
          default: cmd_speed = 8'($urandom);
        endcase
      end else begin
        cmd_valid = 1'b0;
      end
      cycle();
    end
    cmd_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
Command-side stage directly upstream of the motor PWM generator. Accepts speed/direction commands and slews duty_cycle toward the target at a fixed rate. On a direction change it ramps to zero, holds a dead time with the drive disabled, then flips direction and ramps back up. Outputs motor_enable, motor_dir and duty_cycle connect straight to the PWM stage's enable, dir and duty_cycle inputs.

Parameters:
STEP_DIV, 1000, clock cycles per ramp tick (>=1)
STEP, 1, duty change per tick (1..255)
DEADTIME, 50000, cycles spent in DEAD with the drive disabled (>=1)

Ports:
cin  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
cmd_valid  in  1  command strobe
cmd_ready  out  1  block can accept a command
cmd_dir  in  1  target direction (1 fwd, 0 back)
cmd_speed  in  8  target duty magnitude, 0..255
motor_enable  out  1  drive enable to PWM stage
motor_dir  out  1  direction to PWM stage
duty_cycle  out  8  duty to PWM stage
at_target  out  1  duty and dir equal the latched target
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): duty_cycle=0, motor_dir=1, motor_enable=0, cmd_ready=1, at_target=1, busy=0, tgt_speed=0, tgt_dir=1, prescaler=0, state IDLE.
- All outputs are registered. Accept = cmd_valid & cmd_ready. On accept, tgt_speed and tgt_dir load on that edge; their effect on state and duty starts the next cycle.
- Prescaler: free-running counter 0..STEP_DIV-1. tick=1 in the cycle the count equals STEP_DIV-1, then the count wraps to 0. STEP_DIV=1 gives tick every cycle. Commands do not reset the prescaler.
- Slew rule (on tick only): toward target t, if |t-duty|<=STEP then duty=t, else duty +/- STEP. Compute with 9-bit arithmetic so the result never wraps past 255 or below 0.
- States:
  - IDLE: duty=0, motor_enable=0. Target nonzero -> motor_dir=tgt_dir on the transition, go RUN. Target 0 -> stay in IDLE.
  - RUN: slew toward tgt_speed. tgt_dir!=motor_dir -> REVERSE. duty==0 and tgt_speed==0 -> IDLE.
  - REVERSE: slew toward 0. tgt_dir==motor_dir again (new command) -> RUN with no dead time. duty==0 -> DEAD, dead counter loaded with DEADTIME-1.
  - DEAD: motor_enable=0, cmd_ready=0, count down. At 0: motor_dir=tgt_dir. Then RUN if tgt_speed!=0, else IDLE. DEAD lasts exactly DEADTIME cycles.
- motor_enable = 1 in RUN/REVERSE while duty!=0, otherwise 0.
- cmd_ready = 0 only in DEAD (or during estop, see Optional Feature). New commands in RUN/REVERSE retarget mid-ramp.
- at_target = (duty==tgt_speed) & (motor_dir==tgt_dir) & state in {IDLE,RUN}.
- A command identical to the current target is accepted and has no effect. Speed 0 with the opposite dir from RUN: ramp down through REVERSE and DEAD, flip dir, end in IDLE.
- Reset mid-ramp: outputs return to reset values immediately (asynchronously). The PWM stage sees enable=0.

Optional Feature:
MOTOR_ESTOP_EN
- Defined: adds input estop (1 bit, synchronous to cin).
  - While estop=1: duty=0 and motor_enable=0 from the next edge, tgt_speed cleared to 0, cmd_ready=0, state forced to DEAD with the counter held at DEADTIME-1.
  - After estop falls, the normal DEADTIME countdown runs, then the block goes to IDLE.
- Undefined: no estop port and no related logic.

Test Plan:
(All with STEP_DIV=4, STEP=16, DEADTIME=10.)
- Reset, then cmd speed=64 dir=1 -> duty 0,16,32,48,64 on successive ticks, 4 cycles apart; motor_enable=1 from the first nonzero duty; at_target=1 at 64.
- At duty=64 fwd, cmd speed=40 dir=0 -> duty 48,32,16,0; DEAD for exactly 10 cycles with enable=0 and cmd_ready=0; motor_dir=0; duty ramps 16,32,40; at_target=1.
- cmd speed=250 -> duty saturates at 250, never 256/0 wrap; then cmd speed=5 -> steps down by 16 to 10, then lands exactly on 5.
- During REVERSE at duty=32, cmd back to the original dir speed=48 -> no DEAD entered, duty climbs to 48, motor_dir unchanged.
- rst_n low mid-ramp at duty=32 -> duty=0, motor_enable=0 without waiting for a clock edge; after release the block is in IDLE with cmd_ready=1.
- (MOTOR_ESTOP_EN) estop pulse of 3 cycles at duty=128 -> duty=0 next edge; enable stays 0 for 3 + 10 cycles; IDLE; at_target=1 with tgt_speed=0.
